// File: rtl/bist_engine_mc.sv
// bist_engine_mc: scan BIST sequencer. A Galois LFSR feeds NCH chains and a Galois MISR compacts the responses.
// Optional macro BIST_LEARN_EN: the first completed run after reset learns the golden signature.
module bist_engine_mc #(
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 16'h0039,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'h0001,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'h0039,
  parameter int                NCH        = 4,
  parameter int                CHAIN_LEN  = 57,
  parameter int                NPAT       = 2000,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bistmode,
  output logic           bistdone,
  output logic           bistpass,
  output logic           cut_scanmode,
  output logic [NCH-1:0] cut_sdi,
  input  logic [NCH-1:0] cut_sdo
);

  localparam int SH_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PC_W       = $clog2(NPAT + 1);
  localparam int TAP_STRIDE = LFSR_W / NCH;
  localparam logic [SH_W-1:0] SH_LAST  = SH_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PAT_LAST = PC_W'(NPAT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_COMPARE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    logic [LFSR_W-1:0] n;
    n[0] = q[LFSR_W-1];
    for (int i = 1; i < LFSR_W; i++) n[i] = q[i-1] ^ (q[LFSR_W-1] & LFSR_POLY[i]);
    return n;
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic [MISR_W-1:0] d);
    logic [MISR_W-1:0] n;
    n[0] = m[MISR_W-1] ^ d[0];
    for (int i = 1; i < MISR_W; i++) n[i] = m[i-1] ^ (m[MISR_W-1] & MISR_POLY[i]) ^ d[i];
    return n;
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_bm_q, r_scanmode, r_done, r_pass;
  logic [LFSR_W-1:0] r_lfsr;
  logic [MISR_W-1:0] r_misr, w_sdo_ext;
  logic [SH_W-1:0]   r_sh_cnt;
  logic [PC_W-1:0]   r_pat_cnt, w_pat_nxt;
  logic              w_seed, w_lfsr_en, w_misr_en, w_sh_inc, w_sh_clr, w_pat_inc;
  logic              w_cmp, w_res_clr, w_match, w_scan_nxt;
  logic [NCH-1:0]    w_sdi;

  assign w_pat_nxt = r_pat_cnt + PC_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_seed      = 1'b0;
    w_lfsr_en   = 1'b0;
    w_misr_en   = 1'b0;
    w_sh_inc    = 1'b0;
    w_sh_clr    = 1'b0;
    w_pat_inc   = 1'b0;
    w_cmp       = 1'b0;
    w_res_clr   = 1'b0;
    // Any drop of bistmode before DONE abandons the run without a result.
    case (r_state)
      ST_IDLE: begin
        if (bistmode) w_state_nxt = ST_SEED;
        else          w_state_nxt = ST_IDLE;
      end
      ST_SEED: begin
        if (!bistmode) begin
          w_state_nxt = ST_IDLE;
          w_res_clr   = 1'b1;
        end else begin
          w_seed      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT, ST_UNLOAD: begin
        if (!bistmode) begin
          w_state_nxt = ST_IDLE;
          w_res_clr   = 1'b1;
        end else begin
          w_lfsr_en = 1'b1;
          w_misr_en = (r_state == ST_UNLOAD) || (r_pat_cnt != '0);
          if (r_sh_cnt == SH_LAST) begin
            w_sh_clr    = 1'b1;
            w_state_nxt = (r_state == ST_UNLOAD) ? ST_COMPARE : ST_CAPTURE;
          end else begin
            w_sh_inc    = 1'b1;
            w_state_nxt = r_state;
          end
        end
      end
      ST_CAPTURE: begin
        if (!bistmode) begin
          w_state_nxt = ST_IDLE;
          w_res_clr   = 1'b1;
        end else begin
          w_pat_inc = 1'b1;
          if (w_pat_nxt == PAT_LAST) w_state_nxt = ST_UNLOAD;
          else                       w_state_nxt = ST_SHIFT;
        end
      end
      ST_COMPARE: begin
        if (!bistmode) begin
          w_state_nxt = ST_IDLE;
          w_res_clr   = 1'b1;
        end else begin
          w_cmp       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bistmode && !r_bm_q) begin
          w_state_nxt = ST_SEED;
          w_res_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_scan_nxt = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_UNLOAD);
  end

  // State, bistmode edge history and the registered scan-enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_bm_q     <= 1'b0;
      r_scanmode <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bm_q     <= bistmode;
      r_scanmode <= w_scan_nxt;
    end
  end

  // Pattern generator and signature compactor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
      r_misr <= '0;
    end else begin
      if (w_seed)         r_lfsr <= LFSR_SEED;
      else if (w_lfsr_en) r_lfsr <= lfsr_step(r_lfsr);
      if (w_seed)         r_misr <= '0;
      else if (w_misr_en) r_misr <= misr_step(r_misr, w_sdo_ext);
    end
  end

  // Shift and pattern counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_cnt  <= '0;
      r_pat_cnt <= '0;
    end else begin
      if (w_seed || w_sh_clr) r_sh_cnt <= '0;
      else if (w_sh_inc)      r_sh_cnt <= r_sh_cnt + SH_W'(1);
      if (w_seed)             r_pat_cnt <= '0;
      else if (w_pat_inc)     r_pat_cnt <= w_pat_nxt;
    end
  end

`ifdef BIST_LEARN_EN
  logic              r_learn;
  logic [MISR_W-1:0] r_golden;

  // First completed compare after reset captures the reference signature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_learn  <= 1'b1;
      r_golden <= '0;
    end else if (w_cmp && r_learn) begin
      r_learn  <= 1'b0;
      r_golden <= r_misr;
    end
  end

  assign w_match = r_learn ? 1'b1 : (r_misr == r_golden);
`else
  assign w_match = (r_misr == GOLDEN_SIG);
`endif

  // Result flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_res_clr) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_cmp) begin
      r_done <= 1'b1;
      r_pass <= w_match;
    end
  end

  always_comb begin
    w_sdo_ext = '0;
    for (int k = 0; k < NCH; k++) w_sdo_ext[k] = cut_sdo[k];
  end

  // Chains are fed from evenly spaced LFSR stages.
  always_comb begin
    w_sdi = '0;
    if (r_scanmode) begin
      for (int k = 0; k < NCH; k++) w_sdi[k] = r_lfsr[k*TAP_STRIDE];
    end else begin
      w_sdi = '0;
    end
  end

  assign cut_sdi      = w_sdi;
  assign cut_scanmode = r_scanmode;
  assign bistdone     = r_done;
  assign bistpass     = r_pass;

endmodule

// File: tb/tb_bist_engine_mc.sv
// Testbench for bist_engine_mc: a run-level behavioural model checked every cycle on a small
// configuration, plus a second instance with a hand-computed nonzero golden signature.
`timescale 1ns/1ps
module tb_bist_engine_mc;

  localparam int          CL    = 3;
  localparam int          NP    = 2;
  localparam logic [15:0] POLY  = 16'h0039;
  localparam logic [15:0] SEED  = 16'h0001;
  localparam logic [15:0] GOLD  = 16'h0000;
  localparam int          CL2   = 8;
  localparam int          NP2   = 3;
  localparam logic [15:0] GOLD2 = 16'h1C80;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bm  = 1'b0;
  logic       bm2 = 1'b0;
  logic [3:0] sdo  = 4'h0;
  logic [3:0] sdo2 = 4'h0;
  logic       done, pass, scan, done2, pass2, scan2;
  logic [3:0] sdi, sdi2;

  int n_chk  = 0;
  int n_fail = 0;

  bist_engine_mc #(.LFSR_W(16), .LFSR_POLY(POLY), .LFSR_SEED(SEED), .MISR_W(16), .MISR_POLY(POLY),
                   .NCH(4), .CHAIN_LEN(CL), .NPAT(NP), .GOLDEN_SIG(GOLD)) u_dut (
    .clk(clk), .rst(rst), .bistmode(bm), .bistdone(done), .bistpass(pass),
    .cut_scanmode(scan), .cut_sdi(sdi), .cut_sdo(sdo));

  bist_engine_mc #(.LFSR_W(16), .LFSR_POLY(POLY), .LFSR_SEED(SEED), .MISR_W(16), .MISR_POLY(POLY),
                   .NCH(4), .CHAIN_LEN(CL2), .NPAT(NP2), .GOLDEN_SIG(GOLD2)) u_dut2 (
    .clk(clk), .rst(rst), .bistmode(bm2), .bistdone(done2), .bistpass(pass2),
    .cut_scanmode(scan2), .cut_sdi(sdi2), .cut_sdo(sdo2));

  always #5 clk = ~clk;

  // Phase of cycle k of a run (k=0 is the seed cycle): 0 seed, 1 shift, 2 capture, 3 unload, 4 compare.
  function automatic int phase(input int k, input int np, input int cl);
    if (k == 0) return 0;
    if (k <= np * (cl + 1)) return (((k - 1) % (cl + 1)) < cl) ? 1 : 2;
    if (k <= np * (cl + 1) + cl) return 3;
    return 4;
  endfunction

  // Multiply by x modulo the polynomial, then add the injected word.
  function automatic logic [15:0] gstep(input logic [15:0] q, input logic [15:0] inj);
    logic msb;
    msb = q[15];
    return {q[14:0], msb} ^ (msb ? (POLY & 16'hFFFE) : 16'h0000) ^ inj;
  endfunction

  int          m_run;
  int          m_k;
  logic [15:0] m_lfsr, m_misr;
  logic        m_done, m_pass, m_bmq;
`ifdef BIST_LEARN_EN
  logic        m_learn;
  logic [15:0] m_gold;
`endif

  // Model of the small instance: idle (0), running (1), finished (2).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 0; m_k <= 0; m_lfsr <= SEED; m_misr <= 16'h0;
      m_done <= 1'b0; m_pass <= 1'b0; m_bmq <= 1'b0;
`ifdef BIST_LEARN_EN
      m_learn <= 1'b1; m_gold <= 16'h0;
`endif
    end else begin
      m_bmq <= bm;
      if (m_run == 0) begin
        if (bm) begin m_run <= 1; m_k <= 0; m_lfsr <= SEED; m_misr <= 16'h0; end
      end else if (m_run == 1) begin
        if (!bm) begin
          m_run <= 0; m_done <= 1'b0; m_pass <= 1'b0;
        end else begin
          m_k <= m_k + 1;
          case (phase(m_k, NP, CL))
            1: begin
              m_lfsr <= gstep(m_lfsr, 16'h0);
              if ((m_k - 1) / (CL + 1) >= 1) m_misr <= gstep(m_misr, {12'h0, sdo});
            end
            3: begin
              m_lfsr <= gstep(m_lfsr, 16'h0);
              m_misr <= gstep(m_misr, {12'h0, sdo});
            end
            4: begin
              m_run <= 2; m_done <= 1'b1;
`ifdef BIST_LEARN_EN
              m_pass <= m_learn ? 1'b1 : (m_misr == m_gold);
              if (m_learn) begin m_learn <= 1'b0; m_gold <= m_misr; end
`else
              m_pass <= (m_misr == GOLD);
`endif
            end
            default: ;
          endcase
        end
      end else if (bm && !m_bmq) begin
        m_run <= 1; m_k <= 0; m_done <= 1'b0; m_pass <= 1'b0; m_lfsr <= SEED; m_misr <= 16'h0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare the small instance against the model; called once per cycle on the falling edge.
  task automatic cmp_model();
    logic       e_scan;
    logic [3:0] e_sdi;
    int         ph;
    ph     = phase(m_k, NP, CL);
    e_scan = (m_run == 1) && (ph == 1 || ph == 3);
    e_sdi  = e_scan ? {m_lfsr[12], m_lfsr[8], m_lfsr[4], m_lfsr[0]} : 4'h0;
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("scanmode", 32'(scan), 32'(e_scan));
    chk("sdi", 32'(sdi), 32'(e_sdi));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask

  // Launch a run on the small instance; lat = cycle where bistdone is first seen, -2 after abort, -1 on timeout.
  task automatic run1(input int inj_k, input logic [3:0] inj_v, input int abort_k,
                      output int lat, output logic [12:0] tr);
    lat = -1;
    tr  = 13'h0;
    bm  = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (n < 13) tr[12-n] = scan;
      if (done) begin lat = n; break; end
      sdo = (n == inj_k) ? inj_v : 4'h0;
      if (n == abort_k) begin
        bm = 1'b0;
        tick();
        chk("abort_scanmode", 32'(scan), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        lat = -2;
        break;
      end
    end
    sdo = 4'h0;
  endtask

  // Run on the long instance, checking scan-in data against a local LFSR each cycle.
  task automatic run2(input logic [3:0] inj_v, output int lat, output logic pass_o);
    logic [15:0] q;
    int          ph;
    q      = SEED;
    lat    = -1;
    pass_o = 1'b0;
    bm2    = 1'b1;
    for (int n = 0; n < 100; n++) begin
      tick();
      ph = phase(n, NP2, CL2);
      if (done2) begin lat = n; pass_o = pass2; break; end
      chk("scanmode2", 32'(scan2), 32'((ph == 1 || ph == 3) ? 1 : 0));
      chk("sdi2", 32'(sdi2), 32'((ph == 1 || ph == 3) ? {q[12], q[8], q[4], q[0]} : 4'h0));
      if (ph == 1 || ph == 3) q = gstep(q, 16'h0);
      sdo2 = (n == 10) ? inj_v : 4'h0;
    end
    sdo2 = 4'h0;
    bm2  = 1'b0;
  endtask

  int          lat;
  logic [12:0] tr;
  logic        p2;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick();
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_scanmode", 32'(scan), 32'd0);

    // Undisturbed run: signature 0 with sdo tied low.
    run1(-1, 4'h0, -1, lat, tr);
    chk("latency_a", 32'(lat), 32'd13);
    chk("scan_trace", 32'(tr), 32'(13'b0111011101110));
    chk("pass_a", 32'(pass), 32'd1);

    // Held high in DONE: no restart.
    repeat (20) tick();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_scanmode", 32'(scan), 32'd0);

    // Low then high: full repeat with identical result.
    bm = 1'b0; tick();
    run1(-1, 4'h0, -1, lat, tr);
    chk("latency_retrig", 32'(lat), 32'd13);
    chk("pass_retrig", 32'(pass), 32'd1);

    // Fault on chain 2 during unload cycle 2.
    bm = 1'b0; tick();
    run1(10, 4'b0100, -1, lat, tr);
    chk("latency_fault", 32'(lat), 32'd13);
    chk("pass_fault", 32'(pass), 32'd0);

    // Abort at shift cycle 2, then a clean full run.
    bm = 1'b0; tick();
    run1(-1, 4'h0, 2, lat, tr);
    chk("abort_flag", 32'(lat), 32'hFFFF_FFFE);
    run1(-1, 4'h0, -1, lat, tr);
    chk("latency_after_abort", 32'(lat), 32'd13);
    chk("pass_after_abort", 32'(pass), 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    bm = 1'b0; tick();
    bm = 1'b1; tick(); tick(); tick();
    chk("pre_reset_scanmode", 32'(scan), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_scanmode", 32'(scan), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_pass", 32'(pass), 32'd0);
    bm = 1'b0; tick();
    rst = 1'b1; tick(); tick();
    chk("post_reset_scanmode", 32'(scan), 32'd0);
    run1(-1, 4'h0, -1, lat, tr);
    chk("latency_post_reset", 32'(lat), 32'd13);
    chk("pass_post_reset", 32'(pass), 32'd1);

    // Asynchronous reset while DONE with pass set.
    #2 rst = 1'b0;
    #1;
    chk("rst_in_done_done", 32'(done), 32'd0);
    chk("rst_in_done_pass", 32'(pass), 32'd0);
    bm = 1'b0; tick();
    rst = 1'b1; tick();

    // Long instance: single-bit pulse at the first compacted cycle gives 16'h1C80.
    run2(4'b0001, lat, p2);
    chk("latency_long", 32'(lat), 32'd37);
    chk("pass_long", 32'(p2), 32'd1);
    tick();
    run2(4'b0010, lat, p2);
    chk("latency_long_b", 32'(lat), 32'd37);
    chk("pass_long_b", 32'(p2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
